// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer and round-robin arbiter for a bank of gated W-bit latches.
// Every write runs setup, gate-high and hold phases so lat_d is stable around each gate edge.
module latch_bank_wr_ctrl #(
   parameter int unsigned AW       = 2,
   parameter int unsigned W        = 4,
   parameter int unsigned GATE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_a,
   input  logic [AW-1:0]        addr_a,
   input  logic [W-1:0]         data_a,
   output logic                 ack_a,
   input  logic                 req_b,
   input  logic [AW-1:0]        addr_b,
   input  logic [W-1:0]         data_b,
   output logic                 ack_b,
   input  logic                 clr_req,
   output logic                 clr_done,
   output logic [W-1:0]         lat_d,
   output logic [(2**AW)-1:0]   lat_g,
   output logic                 lat_clr,
   output logic                 busy
);

   localparam int unsigned N  = 2**AW;
   localparam int unsigned CW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, ACK, CLR, CDONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            ptr_b;
   logic            gnt_b;
   logic [AW-1:0]   addr_q;
   logic            grant_b_c;

   // B wins when it is the only requester, or when both request and the pointer names B
   assign grant_b_c = req_b && (!req_a || ptr_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ptr_b    <= 1'b0;
         gnt_b    <= 1'b0;
         addr_q   <= '0;
         lat_d    <= '0;
         lat_g    <= '0;
         lat_clr  <= 1'b0;
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         clr_done <= 1'b0;
         busy     <= 1'b0;
      end else begin
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_req) begin
                  lat_clr <= 1'b1;
                  busy    <= 1'b1;
                  cnt     <= CW'(GATE_CYC - 1);
                  state   <= CLR;
               end else if (req_a || req_b) begin
                  gnt_b  <= grant_b_c;
                  addr_q <= grant_b_c ? addr_b : addr_a;
                  lat_d  <= grant_b_c ? data_b : data_a;
                  busy   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               lat_g <= N'(1) << addr_q;
               cnt   <= CW'(GATE_CYC - 1);
               state <= GATE;
            end
            GATE: begin
               if (cnt == '0) begin
                  lat_g <= '0;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               ack_a <= !gnt_b;
               ack_b <= gnt_b;
               state <= ACK;
            end
            ACK: begin
               ptr_b <= !gnt_b;
               busy  <= 1'b0;
               state <= IDLE;
            end
            CLR: begin
               if (cnt == '0) begin
                  lat_clr  <= 1'b0;
                  clr_done <= 1'b1;
                  state    <= CDONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            CDONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               lat_g   <= '0;
               lat_clr <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed bench for latch_bank_wr_ctrl: main instance at GATE_CYC=2, plus GATE_CYC=1 and 3 instances.
module tb_latch_bank_wr_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a, req_b, clr_req;
   logic [1:0] addr_a, addr_b;
   logic [3:0] data_a, data_b;
   logic       ack_a, ack_b, clr_done, lat_clr, busy;
   logic [3:0] lat_d, lat_g;

   logic       s1_req, s3_req;
   logic [1:0] s_addr;
   logic [3:0] s_data;
   logic       zb;
   logic [1:0] za;
   logic [3:0] zd;
   logic       s1_ack_a, s1_ack_b, s1_clr_done, s1_lat_clr, s1_busy;
   logic [3:0] s1_lat_d, s1_lat_g;
   logic       s3_ack_a, s3_ack_b, s3_clr_done, s3_lat_clr, s3_busy;
   logic [3:0] s3_lat_d, s3_lat_g;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   latch_bank_wr_ctrl #(.AW(2), .W(4), .GATE_CYC(2)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
      .clr_req(clr_req), .clr_done(clr_done),
      .lat_d(lat_d), .lat_g(lat_g), .lat_clr(lat_clr), .busy(busy));

   latch_bank_wr_ctrl #(.AW(2), .W(4), .GATE_CYC(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_a(s1_req), .addr_a(s_addr), .data_a(s_data), .ack_a(s1_ack_a),
      .req_b(zb), .addr_b(za), .data_b(zd), .ack_b(s1_ack_b),
      .clr_req(zb), .clr_done(s1_clr_done),
      .lat_d(s1_lat_d), .lat_g(s1_lat_g), .lat_clr(s1_lat_clr), .busy(s1_busy));

   latch_bank_wr_ctrl #(.AW(2), .W(4), .GATE_CYC(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_a(s3_req), .addr_a(s_addr), .data_a(s_data), .ack_a(s3_ack_a),
      .req_b(zb), .addr_b(za), .data_b(zd), .ack_b(s3_ack_b),
      .clr_req(zb), .clr_done(s3_clr_done),
      .lat_d(s3_lat_d), .lat_g(s3_lat_g), .lat_clr(s3_lat_clr), .busy(s3_busy));

   // Per-cycle invariants on all three instances (skipped around reset edges)
   logic [3:0] pg0, pg1, pg3, pd0, pd1, pd3;
   logic       prst = 1'b1;
   always @(negedge clk) begin
      if (!rst && !prst) begin
         total++;
         if ((lat_clr && |lat_g) || $countones(lat_g) > 1 || ((|lat_g || |pg0) && lat_d !== pd0)) begin
            bad++;
            $display("FAIL inv_main g=%b clr=%b d=%h prev_d=%h", lat_g, lat_clr, lat_d, pd0);
         end
         total++;
         if ((s1_lat_clr && |s1_lat_g) || $countones(s1_lat_g) > 1 || ((|s1_lat_g || |pg1) && s1_lat_d !== pd1)) begin
            bad++;
            $display("FAIL inv_gc1 g=%b clr=%b d=%h prev_d=%h", s1_lat_g, s1_lat_clr, s1_lat_d, pd1);
         end
         total++;
         if ((s3_lat_clr && |s3_lat_g) || $countones(s3_lat_g) > 1 || ((|s3_lat_g || |pg3) && s3_lat_d !== pd3)) begin
            bad++;
            $display("FAIL inv_gc3 g=%b clr=%b d=%h prev_d=%h", s3_lat_g, s3_lat_clr, s3_lat_d, pd3);
         end
      end
      prst = rst;
      pg0 = lat_g;    pd0 = lat_d;
      pg1 = s1_lat_g; pd1 = s1_lat_d;
      pg3 = s3_lat_g; pd3 = s3_lat_d;
   end

   task automatic do_reset;
      rst = 1'b1;
      {req_a, req_b, clr_req, s1_req, s3_req} = '0;
      {addr_a, addr_b, s_addr} = '0;
      {data_a, data_b, s_data} = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_a = 1'b1; req_b = 1'b1; clr_req = 1'b1;
      @(negedge clk);
      total++; if (lat_g !== 4'b0)  begin bad++; $display("FAIL rst_lat_g got=%b exp=0000", lat_g); end
      total++; if (lat_d !== 4'h0)  begin bad++; $display("FAIL rst_lat_d got=%h exp=0", lat_d); end
      total++; if (lat_clr !== 1'b0) begin bad++; $display("FAIL rst_lat_clr got=%b exp=0", lat_clr); end
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if ({ack_a, ack_b, clr_done} !== 3'b000) begin
         bad++; $display("FAIL rst_pulses got=%b exp=000", {ack_a, ack_b, clr_done});
      end
      do_reset();
   endtask

   task automatic test_write_a;
      logic [3:0] eg;
      do_reset();
      req_a = 1'b1; addr_a = 2'd2; data_a = 4'hA;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         eg = (c == 2 || c == 3) ? 4'b0100 : 4'b0000;
         total++; if (lat_g !== eg) begin bad++; $display("FAIL wr_a_gate c=%0d got=%b exp=%b", c, lat_g, eg); end
         total++; if (ack_a !== 1'(c == 5)) begin bad++; $display("FAIL wr_a_ack c=%0d got=%b exp=%b", c, ack_a, c == 5); end
         total++; if (busy !== 1'(c <= 5)) begin bad++; $display("FAIL wr_a_busy c=%0d got=%b exp=%b", c, busy, c <= 5); end
         total++; if (lat_d !== 4'hA) begin bad++; $display("FAIL wr_a_data c=%0d got=%h exp=a", c, lat_d); end
         if (c == 5) req_a = 1'b0;
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] eg;
      logic [3:0] ed;
      logic       isb;
      do_reset();
      req_a = 1'b1; addr_a = 2'd0; data_a = 4'h3;
      req_b = 1'b1; addr_b = 2'd1; data_b = 4'h5;
      for (int s = 0; s < 4; s++) begin
         isb = (s % 2 == 1);
         ed  = isb ? 4'h5 : 4'h3;
         for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            eg = (c == 2 || c == 3) ? (isb ? 4'b0010 : 4'b0001) : 4'b0000;
            total++; if (lat_g !== eg) begin bad++; $display("FAIL b2b_gate s=%0d c=%0d got=%b exp=%b", s, c, lat_g, eg); end
            total++; if ({ack_a, ack_b} !== {1'(!isb && c == 5), 1'(isb && c == 5)}) begin
               bad++; $display("FAIL b2b_ack s=%0d c=%0d got=%b%b", s, c, ack_a, ack_b);
            end
            if (c <= 5) begin
               total++; if (lat_d !== ed) begin bad++; $display("FAIL b2b_data s=%0d c=%0d got=%h exp=%h", s, c, lat_d, ed); end
            end
            if (s == 3 && c == 6) begin req_a = 1'b0; req_b = 1'b0; end
         end
      end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy got=%b exp=0", busy); end
   endtask

   task automatic test_clr_mid_gate;
      do_reset();
      req_a = 1'b1; addr_a = 2'd3; data_a = 4'h6;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         case (c)
            2: begin
               total++; if (lat_g !== 4'b1000) begin bad++; $display("FAIL cmg_gate got=%b exp=1000", lat_g); end
               clr_req = 1'b1; req_b = 1'b1; addr_b = 2'd0; data_b = 4'hC;
            end
            5: begin
               total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL cmg_ack_a got=%b exp=1", ack_a); end
               req_a = 1'b0;
            end
            6: begin
               total++; if ({lat_clr, busy} !== 2'b00) begin bad++; $display("FAIL cmg_idle clr_busy got=%b exp=00", {lat_clr, busy}); end
            end
            7, 8: begin
               total++; if ({lat_clr, lat_g} !== 5'b1_0000) begin bad++; $display("FAIL cmg_clr c=%0d got=%b exp=10000", c, {lat_clr, lat_g}); end
               total++; if (lat_d !== 4'h6) begin bad++; $display("FAIL cmg_clr_d c=%0d got=%h exp=6", c, lat_d); end
            end
            9: begin
               total++; if ({clr_done, lat_clr} !== 2'b10) begin bad++; $display("FAIL cmg_done got=%b exp=10", {clr_done, lat_clr}); end
               clr_req = 1'b0;
            end
            11: begin
               total++; if (lat_d !== 4'hC) begin bad++; $display("FAIL cmg_b_data got=%h exp=c", lat_d); end
            end
            12: begin
               total++; if (lat_g !== 4'b0001) begin bad++; $display("FAIL cmg_b_gate got=%b exp=0001", lat_g); end
            end
            15: begin
               total++; if (ack_b !== 1'b1) begin bad++; $display("FAIL cmg_ack_b got=%b exp=1", ack_b); end
               req_b = 1'b0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_clr_priority;
      do_reset();
      req_a = 1'b1; addr_a = 2'd1; data_a = 4'h7;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 5) begin
            total++; if (ack_a !== 1'b1) begin bad++; $display("FAIL cp_pre_ack got=%b exp=1", ack_a); end
            req_a = 1'b0;
         end
      end
      clr_req = 1'b1;
      req_b = 1'b1; addr_b = 2'd2; data_b = 4'h9;
      req_a = 1'b1; addr_a = 2'd1; data_a = 4'h4;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         case (c)
            1, 2: begin
               total++; if ({lat_clr, lat_g} !== 5'b1_0000) begin bad++; $display("FAIL cp_clr c=%0d got=%b exp=10000", c, {lat_clr, lat_g}); end
            end
            3: begin
               total++; if (clr_done !== 1'b1) begin bad++; $display("FAIL cp_done got=%b exp=1", clr_done); end
               clr_req = 1'b0;
            end
            4: begin
               total++; if ({clr_done, busy} !== 2'b00) begin bad++; $display("FAIL cp_idle got=%b exp=00", {clr_done, busy}); end
            end
            5: begin
               total++; if (lat_d !== 4'h9) begin bad++; $display("FAIL cp_b_first got=%h exp=9", lat_d); end
            end
            6: begin
               total++; if (lat_g !== 4'b0100) begin bad++; $display("FAIL cp_b_gate got=%b exp=0100", lat_g); end
            end
            9: begin
               total++; if ({ack_a, ack_b} !== 2'b01) begin bad++; $display("FAIL cp_ack_b got=%b exp=01", {ack_a, ack_b}); end
               req_b = 1'b0;
            end
            11: begin
               total++; if (lat_d !== 4'h4) begin bad++; $display("FAIL cp_a_data got=%h exp=4", lat_d); end
            end
            12: begin
               total++; if (lat_g !== 4'b0010) begin bad++; $display("FAIL cp_a_gate got=%b exp=0010", lat_g); end
            end
            15: begin
               total++; if ({ack_a, ack_b} !== 2'b10) begin bad++; $display("FAIL cp_ack_a got=%b exp=10", {ack_a, ack_b}); end
               req_a = 1'b0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_reset_mid_gate;
      do_reset();
      req_a = 1'b1; addr_a = 2'd0; data_a = 4'h1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 5) req_a = 1'b0;
      end
      req_b = 1'b1; addr_b = 2'd3; data_b = 4'hE;
      repeat (2) @(negedge clk);
      total++; if (lat_g !== 4'b1000) begin bad++; $display("FAIL rmg_gate got=%b exp=1000", lat_g); end
      #2 rst = 1'b1;
      #1;
      total++; if ({lat_g, lat_d} !== 8'h00) begin bad++; $display("FAIL rmg_async g_d got=%b_%h exp=0000_0", lat_g, lat_d); end
      total++; if ({busy, ack_a, ack_b} !== 3'b000) begin bad++; $display("FAIL rmg_async busy_ack got=%b exp=000", {busy, ack_a, ack_b}); end
      @(negedge clk);
      #2 rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            total++; if (lat_d !== 4'hE) begin bad++; $display("FAIL rmg_b_data got=%h exp=e", lat_d); end
         end
         if (c == 2) begin
            total++; if (lat_g !== 4'b1000) begin bad++; $display("FAIL rmg_b_gate got=%b exp=1000", lat_g); end
         end
         total++; if ({ack_a, ack_b} !== {1'b0, 1'(c == 5)}) begin bad++; $display("FAIL rmg_ack c=%0d got=%b%b", c, ack_a, ack_b); end
         if (c == 5) req_b = 1'b0;
      end
   endtask

   task automatic test_sweep;
      logic [3:0] e1, e3;
      do_reset();
      s1_req = 1'b1; s3_req = 1'b1; s_addr = 2'd1; s_data = 4'h9;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         e1 = (c == 2) ? 4'b0010 : 4'b0000;
         e3 = (c >= 2 && c <= 4) ? 4'b0010 : 4'b0000;
         total++; if (s1_lat_g !== e1) begin bad++; $display("FAIL sw1_gate c=%0d got=%b exp=%b", c, s1_lat_g, e1); end
         total++; if (s3_lat_g !== e3) begin bad++; $display("FAIL sw3_gate c=%0d got=%b exp=%b", c, s3_lat_g, e3); end
         total++; if (s1_ack_a !== 1'(c == 4)) begin bad++; $display("FAIL sw1_ack c=%0d got=%b exp=%b", c, s1_ack_a, c == 4); end
         total++; if (s3_ack_a !== 1'(c == 6)) begin bad++; $display("FAIL sw3_ack c=%0d got=%b exp=%b", c, s3_ack_a, c == 6); end
         if (c == 5) begin
            total++; if (s1_busy !== 1'b0) begin bad++; $display("FAIL sw1_busy got=%b exp=0", s1_busy); end
         end
         if (c == 7) begin
            total++; if (s3_busy !== 1'b0) begin bad++; $display("FAIL sw3_busy got=%b exp=0", s3_busy); end
         end
         if (c == 4) s1_req = 1'b0;
         if (c == 6) s3_req = 1'b0;
      end
   endtask

   initial begin
      zb = 1'b0; za = '0; zd = '0;
      {req_a, req_b, clr_req, s1_req, s3_req} = '0;
      {addr_a, addr_b, s_addr} = '0;
      {data_a, data_b, s_data} = '0;
      test_reset();
      test_write_a();
      test_back_to_back();
      test_clr_mid_gate();
      test_clr_priority();
      test_reset_mid_gate();
      test_sweep();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/latch_bank_wr_ctrl.md
Name: latch_bank_wr_ctrl

Overview:
- Write sequencer and arbiter for a bank of N level-sensitive W-bit latches: positive-gate latches with a clear input.
- Two requesters, A and B, share the bank under round-robin arbitration. A separate bulk-clear command is also served.
- Each write drives the shared latch data bus and a one-hot gate bus. Phases are setup, gate-high, then hold, so the bus is stable around every gate edge.
- Sits between synchronous logic and the latch array; it is the only driver of the latches' g, d and clr inputs.

Parameters:
- AW, 2, latch address width; N = 2**AW latches.
- W, 4, latch data width.
- GATE_CYC, 2, number of clk cycles the gate (or clr) is held high; legal values are 1 and above.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A write request (level).
- addr_a  in  AW  requester A target latch.
- data_a  in  W  requester A write data.
- ack_a  out  1  one-cycle completion pulse to requester A.
- req_b  in  1  requester B write request (level).
- addr_b  in  AW  requester B target latch.
- data_b  in  W  requester B write data.
- ack_b  out  1  one-cycle completion pulse to requester B.
- clr_req  in  1  bulk-clear request (level).
- clr_done  out  1  one-cycle clear-completion pulse.
- lat_d  out  W  shared latch data bus.
- lat_g  out  N  one-hot gate bus; bit i drives the gate of latch i.
- lat_clr  out  1  shared clear to all latches.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state goes to IDLE; lat_g=0, lat_clr=0, lat_d=0.
  - ack_a, ack_b, clr_done and busy all go to 0.
  - The round-robin pointer is set to A.
  - Latch contents after a mid-write reset are undefined; the requester must reissue the write.
- All outputs are registered.
- Requester protocol:
  - Hold req, addr and data stable until ack is seen; drop req on the clock after ack.
  - A request that drops before its ack is not supported.
- FSM states: IDLE, SETUP, GATE, HOLD, ACK, CLR, CDONE.
- IDLE:
  - If clr_req=1, go to CLR. Clear has priority over writes.
  - Else if exactly one of req_a or req_b is high, grant it.
  - Else if both are high, grant the requester named by the pointer.
  - On a grant, capture the granter's addr and data into internal registers, then go to SETUP.
  - Requests arriving outside IDLE are not sampled; a pending level request is served at the next IDLE.
- SETUP (1 cycle): lat_d = captured data; lat_g = 0.
- GATE (GATE_CYC cycles): lat_g[addr] = 1 and all other bits 0; lat_d held. A down-counter sizes this phase.
- HOLD (1 cycle): lat_g = 0; lat_d still held.
- ACK (1 cycle):
  - The ack of the granted requester is 1.
  - The pointer moves to the other requester.
  - lat_d is held; next state is IDLE.
- CLR (GATE_CYC cycles): lat_clr = 1; lat_g = 0.
- CDONE (1 cycle): lat_clr = 0; clr_done = 1; next state is IDLE. The pointer is unchanged.
- Latency, counting the IDLE cycle that samples the request as cycle 0:
  - lat_g is high in cycles 2 .. 1+GATE_CYC.
  - ack is high in cycle 3+GATE_CYC.
  - Write throughput is one per GATE_CYC+4 cycles.
- Invariants:
  - lat_g is never high while lat_clr=1.
  - At most one lat_g bit is ever high.
  - lat_d never changes while any lat_g bit is high, or in the cycle before or after a gate is high.
- lat_d keeps its last value in IDLE; it is not cleared by completion.

Test Plan:
- Reset, then req_a=1, addr_a=2, data_a=4'hA (GATE_CYC=2) -> lat_d=A from cycle 1; lat_g=4'b0100 in cycles 2-3; lat_g=0 in cycle 4; ack_a pulses in cycle 5; busy low in cycle 6.
- req_a and req_b both held continuously (A: addr 0, data 3; B: addr 1, data 5) -> grant order A, B, A, B; each ack is a single cycle; lat_g alternates 0001 then 0010.
- clr_req raised while an A write is in GATE -> the A write completes with ack_a; the next IDLE enters CLR; lat_clr=1 for 2 cycles; clr_done pulses; a pending req_b is then served.
- clr_req and req_b raised in the same IDLE cycle -> CLR is served first; the B write follows; the pointer is unchanged by the clear.
- rst asserted mid-GATE -> lat_g=0, lat_d=0 and busy=0 immediately, with no ack; after release, a held req_b is granted because the pointer reset to A and A is not requesting.
- Parameter sweep GATE_CYC=1 and GATE_CYC=3 -> gate width is exactly GATE_CYC cycles; ack arrives in cycle 3+GATE_CYC; the invariants hold on every cycle, checked by assertions.
